// File: rtl/matrix_display_scheduler_pkg.sv
// Shared constants, segment table and FSM encoding for the matrix display scheduler.
package matrix_display_scheduler_pkg;

  localparam int unsigned ELEM_W   = 8;
  localparam int unsigned GRID     = 5;
  localparam int unsigned MATRIX_W = 200;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Digit code the encoder renders as a minus sign.
  localparam logic [3:0] DIGIT_MINUS = 4'd10;

  typedef enum logic [1:0] {
    StIdle,
    StShow,
    StPaused
  } state_e;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Sizes outside 2..5 fall back to the full grid.
  function automatic logic [2:0] clamp_size(input logic [2:0] s);
    return (s >= 3'd2 && s <= 3'd5) ? s : 3'(GRID);
  endfunction

endpackage

// File: rtl/matrix_display_scheduler_if.sv
// Coprocessor-side controls and HEX display outputs of the matrix display scheduler.
interface matrix_display_scheduler_if;
  import matrix_display_scheduler_pkg::*;

  logic                load;
  logic [MATRIX_W-1:0] matrix_in;
  logic [2:0]          matrix_size;
  logic                run_en;
  logic                step;
  logic [6:0]          Display0;
  logic [6:0]          Display1;
  logic [6:0]          Display2;
  logic [6:0]          Display3;
  logic [6:0]          Display4;
  logic [6:0]          Display5;
  logic                scan_wrap;

  modport master (
    output load, matrix_in, matrix_size, run_en, step,
    input  Display0, Display1, Display2, Display3, Display4, Display5, scan_wrap
  );

  modport slave (
    input  load, matrix_in, matrix_size, run_en, step,
    output Display0, Display1, Display2, Display3, Display4, Display5, scan_wrap
  );

endinterface

// File: rtl/matrix_display_scheduler_seg7_encoder.sv
// Combinational 7-segment encoder: decimal digit, minus code or blank to active-low segments.
module seg7_encoder
  import matrix_display_scheduler_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else if (digit_i == DIGIT_MINUS) begin
      seg_o = SEG_MINUS;
    end else begin
      seg_o = seg_digit(digit_i);
    end
  end

endmodule

// File: rtl/matrix_display_scheduler.sv
// Snapshots a 5x5 signed result matrix and scans its active NxN block onto six HEX digits,
// either paced by an internal prescaler or stepped manually.
module matrix_display_scheduler
  import matrix_display_scheduler_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1
) (
  input logic                        clk,
  input logic                        reset,
  matrix_display_scheduler_if.slave  bus
);

  localparam int unsigned Period = CLK_HZ / TICK_HZ;
  localparam int unsigned PrescW = $clog2(Period);

  state_e              state_q, state_d;
  logic [MATRIX_W-1:0] snap_q, snap_d;
  logic [2:0]          n_q, n_d, row_q, row_d, col_q, col_d;
  logic [PrescW-1:0]   presc_q, presc_d;
  logic                wrap_q, wrap_d;
  logic                tick, advance;
  logic [6:0]          disp_q [6];
  logic [6:0]          seg [6];
  logic [3:0]          dig [6];
  logic                blk [6];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.load) begin
      state_d = bus.run_en ? StShow : StPaused;
    end else begin
      unique case (state_q)
        StShow:   if (!bus.run_en) state_d = StPaused;
        StPaused: if (bus.run_en)  state_d = StShow;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    tick    = (state_q == StShow) && (presc_q == PrescW'(Period - 1));
    advance = tick || ((state_q == StPaused) && bus.step);
  end

  always_comb begin
    snap_d  = snap_q;
    n_d     = n_q;
    row_d   = row_q;
    col_d   = col_q;
    wrap_d  = 1'b0;
    presc_d = '0;
    // Counter only survives while staying in SHOW, so every entry restarts a full period.
    if (!bus.load && state_q == StShow && state_d == StShow) begin
      presc_d = tick ? '0 : presc_q + PrescW'(1);
    end
    if (bus.load) begin
      snap_d = bus.matrix_in;
      n_d    = clamp_size(bus.matrix_size);
      row_d  = '0;
      col_d  = '0;
    end else if (advance) begin
      if (col_q != n_q - 3'd1) begin
        col_d = col_q + 3'd1;
      end else begin
        col_d = '0;
        if (row_q != n_q - 3'd1) begin
          row_d = row_q + 3'd1;
        end else begin
          row_d  = '0;
          wrap_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q  <= '0;
      n_q     <= 3'(GRID);
      row_q   <= '0;
      col_q   <= '0;
      presc_q <= '0;
      wrap_q  <= 1'b0;
      for (int i = 0; i < 6; i++) disp_q[i] <= SEG_BLANK;
    end else begin
      snap_q  <= snap_d;
      n_q     <= n_d;
      row_q   <= row_d;
      col_q   <= col_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
      disp_q  <= seg;
    end
  end

  logic [4:0]        idx;
  logic [ELEM_W-1:0] elem;
  logic [8:0]        mag;
  logic [3:0]        hund, tens, units;
  logic [6:0]        rem;
  logic              idle;

  always_comb begin
    idx  = {2'b00, row_q} * 5'd5 + {2'b00, col_q};
    elem = '0;
    for (int k = 0; k < GRID * GRID; k++) begin
      if (idx == 5'(k)) elem = snap_q[k*ELEM_W +: ELEM_W];
    end
    // 9-bit magnitude so -128 maps to 128.
    mag   = elem[7] ? 9'(9'd256 - {1'b0, elem}) : {1'b0, elem};
    hund  = 4'(mag / 9'd100);
    rem   = 7'(mag - {5'b0, hund} * 9'd100);
    tens  = 4'(rem / 7'd10);
    units = 4'(rem - {3'b0, tens} * 7'd10);
    idle  = (state_q == StIdle);

    dig[0] = units;          blk[0] = idle;
    dig[1] = tens;           blk[1] = idle || (hund == 4'd0 && tens == 4'd0);
    dig[2] = hund;           blk[2] = idle || (hund == 4'd0);
    dig[3] = DIGIT_MINUS;    blk[3] = idle || !elem[7];
    dig[4] = {1'b0, col_q};  blk[4] = idle;
    dig[5] = {1'b0, row_q};  blk[5] = idle;
  end

  for (genvar g = 0; g < 6; g++) begin : g_enc
    seg7_encoder u_enc (
      .digit_i (dig[g]),
      .blank_i (blk[g]),
      .seg_o   (seg[g])
    );
  end

  assign bus.Display0  = disp_q[0];
  assign bus.Display1  = disp_q[1];
  assign bus.Display2  = disp_q[2];
  assign bus.Display3  = disp_q[3];
  assign bus.Display4  = disp_q[4];
  assign bus.Display5  = disp_q[5];
  assign bus.scan_wrap = wrap_q;

endmodule

// File: tb/tb_matrix_display_scheduler.sv
// Scoreboard bench: a cycle-level behavioural model predicts displays and scan_wrap each edge.
module tb_matrix_display_scheduler;

  localparam int PERIOD = 10;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] MI = 7'b0111111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  matrix_display_scheduler_if bus ();

  matrix_display_scheduler #(
    .CLK_HZ  (10),
    .TICK_HZ (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [42:0] exp_q [$];

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // Model state: mode 0 idle, 1 auto, 2 paused; position k is linear within the NxN block.
  int           m_mode = 0;
  logic [199:0] m_snap = '0;
  int           m_n = 5, m_k = 0, m_cnt = 0;
  logic [41:0]  m_d;
  logic         m_w, m_adv;

  function automatic logic [41:0] model_disp();
    int row, col, v, m, h, t, u;
    logic signed [7:0] e;
    logic [6:0] d0, d1, d2, d3;
    if (m_mode == 0) return {6{BL}};
    row = m_k / m_n;
    col = m_k % m_n;
    e = m_snap[(row*5+col)*8 +: 8];
    v = int'(e);
    m = (v < 0) ? -v : v;
    h = m / 100;
    t = (m / 10) % 10;
    u = m % 10;
    d2 = (h == 0) ? BL : seg_tab[h];
    d1 = (h == 0 && t == 0) ? BL : seg_tab[t];
    d0 = seg_tab[u];
    d3 = (v < 0) ? MI : BL;
    return {seg_tab[row], seg_tab[col], d3, d2, d1, d0};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_snap = '0; m_k = 0; m_cnt = 0; m_n = 5;
      exp_q.push_back({1'b0, {6{BL}}});
    end else begin
      m_d = model_disp();
      m_w = 1'b0;
      m_adv = 1'b0;
      if (bus.load) begin
        m_snap = bus.matrix_in;
        m_n = (bus.matrix_size >= 2 && bus.matrix_size <= 5) ? int'(bus.matrix_size) : 5;
        m_k = 0;
        m_cnt = 0;
        m_mode = bus.run_en ? 1 : 2;
      end else if (m_mode == 1) begin
        m_cnt++;
        if (m_cnt == PERIOD) begin m_cnt = 0; m_adv = 1'b1; end
        if (!bus.run_en) m_mode = 2;
      end else if (m_mode == 2) begin
        if (bus.step) m_adv = 1'b1;
        if (bus.run_en) begin m_mode = 1; m_cnt = 0; end
      end
      if (m_adv) begin
        m_k++;
        if (m_k == m_n * m_n) begin m_k = 0; m_w = 1'b1; end
      end
      exp_q.push_back({m_w, m_d});
    end
  end

  logic [42:0] act, expv;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      act = {bus.scan_wrap, bus.Display5, bus.Display4, bus.Display3,
             bus.Display2, bus.Display1, bus.Display0};
      checks++;
      if (act !== expv) begin
        errors++;
        if (errors <= 20)
          $display("FAIL scan t=%0t actual=%h required=%h", $time, act, expv);
      end
    end
  end

  function automatic logic [199:0] rand_mat();
    logic [223:0] r;
    for (int i = 0; i < 7; i++) r[i*32 +: 32] = $urandom;
    return r[199:0];
  endfunction

  task automatic do_load(input logic [2:0] size, input logic [199:0] mat, input logic run);
    @(negedge clk);
    bus.load = 1'b1; bus.matrix_in = mat; bus.matrix_size = size; bus.run_en = run;
    @(negedge clk);
    bus.load = 1'b0; bus.matrix_in = rand_mat(); bus.matrix_size = 3'($urandom);
  endtask

  task automatic pulse_step();
    @(negedge clk); bus.step = 1'b1;
    @(negedge clk); bus.step = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [199:0] mat;
  logic         found;

  initial begin
    bus.load = 1'b0; bus.step = 1'b0; bus.run_en = 1'b0;
    bus.matrix_in = '0; bus.matrix_size = '0;
    cyc(3);
    #2 reset = 1'b0;

    // Idle: controls must not wake the block.
    repeat (50) begin
      @(negedge clk);
      bus.step = 1'($urandom); bus.run_en = 1'($urandom);
    end
    bus.step = 1'b0;

    mat = rand_mat(); mat[7:0] = 8'h80;
    do_load(3'd2, mat, 1'b1);
    cyc(90);

    mat = rand_mat(); mat[7:0] = 8'd7; mat[15:8] = 8'd100;
    do_load(3'd2, mat, 1'b0);
    cyc(5); pulse_step(); cyc(5);

    do_load(3'd5, rand_mat(), 1'b0);
    cyc(100);
    repeat (6) begin pulse_step(); cyc(2); end
    cyc(3);
    bus.run_en = 1'b1;
    cyc(3); pulse_step(); cyc(20);

    // Load landing on the tick that would wrap from (1,1).
    do_load(3'd2, rand_mat(), 1'b1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (m_mode == 1 && m_k == 3 && m_cnt == PERIOD - 1) found = 1'b1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL tick_wait actual=timeout required=tick at (1,1)");
    end
    bus.load = 1'b1; bus.matrix_in = rand_mat(); bus.matrix_size = 3'd2;
    @(negedge clk);
    bus.load = 1'b0;
    cyc(30);

    do_load(3'd7, rand_mat(), 1'b1);
    cyc(260);

    // Reset mid-scan at (2,3).
    do_load(3'd5, rand_mat(), 1'b0);
    repeat (13) pulse_step();
    cyc(3);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.scan_wrap, bus.Display5, bus.Display4, bus.Display3, bus.Display2,
         bus.Display1, bus.Display0} !== {1'b0, {6{BL}}}) begin
      errors++;
      $display("FAIL reset_blank actual=%h required=%h",
               {bus.Display5, bus.Display4, bus.Display3, bus.Display2, bus.Display1,
                bus.Display0}, {6{BL}});
    end
    cyc(2);
    #2 reset = 1'b0;
    bus.run_en = 1'b0;
    repeat (3) pulse_step();
    bus.run_en = 1'b1;
    cyc(25);

    // Random traffic.
    repeat (1500) begin
      @(negedge clk);
      bus.step = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) bus.run_en = ~bus.run_en;
      bus.matrix_in = rand_mat();
      bus.matrix_size = 3'($urandom);
      bus.load = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    bus.load = 1'b0; bus.step = 1'b0;
    cyc(3);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
